// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: funct3 access codes, control-bit positions
// inside the WB/M control groups, and the EX/MEM and MEM/WB register layouts.
package rv_pipe_pkg;

    localparam int XLEN  = 32;
    localparam int WB_W  = 2;
    localparam int M_W   = 3;
    localparam int F3_W  = 3;
    localparam int RD_W  = 5;

    // WB = {regWrite, memToReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    // M = {branch, memRead, memWrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    localparam logic [F3_W-1:0] F3_B  = 3'b000;
    localparam logic [F3_W-1:0] F3_H  = 3'b001;
    localparam logic [F3_W-1:0] F3_W_ = 3'b010;
    localparam logic [F3_W-1:0] F3_BU = 3'b100;
    localparam logic [F3_W-1:0] F3_HU = 3'b101;

    localparam int EXMEM_W = WB_W + M_W + XLEN + 1 + XLEN + XLEN + F3_W + RD_W;
    localparam int MEMWB_W = WB_W + XLEN + XLEN + RD_W + 1;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [XLEN-1:0] pc_branch;
        logic            zero;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] data;
        logic [F3_W-1:0] funct3;
        logic [RD_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [XLEN-1:0] mem_data;
        logic [XLEN-1:0] alu;
        logic [RD_W-1:0] rd;
        logic            misalign;
    } memwb_t;

endpackage

// File: rtl/dmem_bytelane.sv
// Data memory built from four independent byte lanes: asynchronous read,
// synchronous per-lane write enable. Contents are never cleared.
module dmem_bytelane #(
    parameter int DMEM_WORDS = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_be,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DMEM_WORDS];

        // Write this lane only when its byte enable is set
        always_ff @(posedge clock) begin
            if (i_be[g]) r_mem[i_addr] <= i_wdata[8*g +: 8];
        end

        assign o_rdata[8*g +: 8] = r_mem[i_addr];
    end

endmodule

// File: rtl/mem_stage_pip.sv
// MEM stage: EX/MEM register, branch resolution, byte/half/word data memory
// access with alignment check and load extension, and the MEM/WB register.
module mem_stage_pip
    import rv_pipe_pkg::*;
#(
    parameter int DMEM_WORDS = 256,
    parameter int ADDR_W     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic [1:0]  control_WB_in,
    input  logic [2:0]  control_M_in,
    input  logic [31:0] PC_branch_in,
    input  logic        zero_in,
    input  logic [31:0] ALU_in,
    input  logic [31:0] readDataB_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    output logic        PCSrc_out,
    output logic [31:0] PC_branch_out,
    output logic [1:0]  control_WB_out,
    output logic [31:0] memData_out,
    output logic [31:0] ALU_out,
    output logic [4:0]  rd_out,
    output logic        misalign_out
);

    exmem_t            r_exmem;
    memwb_t            r_memwb;
    exmem_t            w_exmem_in;
    logic [ADDR_W-1:0] w_word;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_access;
    logic              w_misalign;
    logic              w_store;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic [31:0]       w_load;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign w_exmem_in = '{wb: control_WB_in, m: control_M_in, pc_branch: PC_branch_in,
                          zero: zero_in, alu: ALU_in, data: readDataB_in,
                          funct3: funct3_in, rd: rd_in};

    // Upper address bits are ignored: the word index wraps modulo DMEM_WORDS
    assign w_word     = r_exmem.alu[ADDR_W+1:2];
    assign w_is_half  = (r_exmem.funct3 == F3_H) || (r_exmem.funct3 == F3_HU);
    assign w_is_word  = (r_exmem.funct3 == F3_W_);
    assign w_access   = r_exmem.m[M_MEMREAD] | r_exmem.m[M_MEMWRITE];
    assign w_misalign = w_access & ((w_is_half & r_exmem.alu[0]) |
                                    (w_is_word & (r_exmem.alu[1:0] != 2'b00)));
    // Reset and stall both block the write that would land on this edge
    assign w_store    = r_exmem.m[M_MEMWRITE] & ~stall_in & ~reset & ~w_misalign;

    // Byte enables and lane-replicated write data for the store size
    always_comb begin
        w_be    = '0;
        w_wdata = r_exmem.data;
        case (r_exmem.funct3)
            F3_B: begin
                w_be    = 4'b0001 << r_exmem.alu[1:0];
                w_wdata = {4{r_exmem.data[7:0]}};
            end
            F3_H: begin
                w_be    = r_exmem.alu[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_exmem.data[15:0]}};
            end
            F3_W_:   w_be = 4'b1111;
            default: w_be = '0;
        endcase
        if (!w_store) w_be = '0;
    end

    dmem_bytelane #(
        .DMEM_WORDS (DMEM_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_dmem (
        .clock   (clock),
        .i_addr  (w_word),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign w_byte = w_rdata[{r_exmem.alu[1:0], 3'b000} +: 8];
    assign w_half = r_exmem.alu[1] ? w_rdata[31:16] : w_rdata[15:0];

    // Load extension; zero for non-loads, load+store combos and misaligned slots
    always_comb begin
        w_load = '0;
        if (r_exmem.m[M_MEMREAD] && !r_exmem.m[M_MEMWRITE] && !w_misalign) begin
            case (r_exmem.funct3)
                F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
                F3_H:    w_load = {{16{w_half[15]}}, w_half};
                F3_W_:   w_load = w_rdata;
                F3_BU:   w_load = {24'b0, w_byte};
                F3_HU:   w_load = {16'b0, w_half};
                default: w_load = '0;
            endcase
        end
    end

    // EX/MEM register: flush inserts a bubble, stall holds
    always_ff @(posedge clock) begin
        if (reset) begin
            r_exmem <= '0;
        end else if (flush_in) begin
            r_exmem      <= w_exmem_in;
            r_exmem.wb   <= '0;
            r_exmem.m    <= '0;
        end else if (!stall_in) begin
            r_exmem <= w_exmem_in;
        end
    end

    // MEM/WB register: advances from EX/MEM unless stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            r_memwb <= '0;
        end else if (!stall_in) begin
            r_memwb.wb       <= r_exmem.wb;
            r_memwb.mem_data <= w_load;
            r_memwb.alu      <= r_exmem.alu;
            r_memwb.rd       <= r_exmem.rd;
            r_memwb.misalign <= w_misalign;
        end
    end

    assign PCSrc_out      = r_exmem.m[M_BRANCH] & r_exmem.zero;
    assign PC_branch_out  = r_exmem.pc_branch;
    assign control_WB_out = r_memwb.wb;
    assign memData_out    = r_memwb.mem_data;
    assign ALU_out        = r_memwb.alu;
    assign rd_out         = r_memwb.rd;
    assign misalign_out   = r_memwb.misalign;

endmodule

// File: tb/tb_mem_stage_pip.sv
// Bench for mem_stage_pip: directed scenarios plus randomized traffic, all
// checked against a byte-addressed memory model that retires one instruction
// per unstalled edge in program order.
module tb_mem_stage_pip;
    import rv_pipe_pkg::*;

    logic        clock = 1'b0;
    logic        reset, stall_in, flush_in, zero_in;
    logic [1:0]  control_WB_in;
    logic [2:0]  control_M_in, funct3_in;
    logic [31:0] PC_branch_in, ALU_in, readDataB_in;
    logic [4:0]  rd_in;
    logic        PCSrc_out, misalign_out;
    logic [31:0] PC_branch_out, memData_out, ALU_out;
    logic [1:0]  control_WB_out;
    logic [4:0]  rd_out;

    mem_stage_pip dut (
        .clock(clock), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .control_WB_in(control_WB_in), .control_M_in(control_M_in),
        .PC_branch_in(PC_branch_in), .zero_in(zero_in), .ALU_in(ALU_in),
        .readDataB_in(readDataB_in), .funct3_in(funct3_in), .rd_in(rd_in),
        .PCSrc_out(PCSrc_out), .PC_branch_out(PC_branch_out),
        .control_WB_out(control_WB_out), .memData_out(memData_out),
        .ALU_out(ALU_out), .rd_out(rd_out), .misalign_out(misalign_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        bit [1:0]  wb;
        bit [2:0]  m;
        bit [31:0] pc;
        bit        zero;
        bit [31:0] alu;
        bit [31:0] data;
        bit [2:0]  f3;
        bit [4:0]  rd;
    } ins_t;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [7:0]  mmem [1024];
    ins_t        exm;
    bit          exm_bub;
    logic [1:0]  e_wb;
    logic [31:0] e_md, e_alu;
    logic [4:0]  e_rd;
    logic        e_mis;
    bit          e_v;

    function automatic ins_t mk(input bit [1:0] wb, input bit [2:0] m, input bit [2:0] f3,
                                input bit [31:0] alu, input bit [31:0] data);
        ins_t t;
        t      = '0;
        t.wb   = wb;
        t.m    = m;
        t.f3   = f3;
        t.alu  = alu;
        t.data = data;
        t.rd   = alu[4:0] ^ data[4:0] ^ 5'd7;
        return t;
    endfunction

    function automatic ins_t st(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
        return mk(2'b00, 3'b001, f3, a, d);
    endfunction

    function automatic ins_t ld(input bit [2:0] f3, input bit [31:0] a);
        return mk(2'b11, 3'b010, f3, a, 32'h0);
    endfunction

    // Retire one instruction through MEM: load reads the current model memory,
    // then a store updates it. Byte address = ALU mod 1024, little-endian.
    task automatic retire(input ins_t e, input bit bub);
        int sz, ba;
        logic [31:0] v;
        ba = int'(e.alu[9:0]);
        sz = (e.f3 == 3'd0 || e.f3 == 3'd4) ? 1 :
             (e.f3 == 3'd1 || e.f3 == 3'd5) ? 2 : (e.f3 == 3'd2) ? 4 : 0;
        e_mis = (e.m[1] || e.m[0]) && ((sz == 2 && ba % 2 != 0) || (sz == 4 && ba % 4 != 0));
        e_md  = 32'h0;
        if (e.m[1] && !e.m[0] && !e_mis && sz > 0) begin
            v = 32'h0;
            for (int k = 0; k < sz; k++) v = v | (32'(mmem[ba + k]) << (8 * k));
            if (e.f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (e.f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            e_md = v;
        end
        if (e.m[0] && !e_mis && e.f3 <= 3'd2)
            for (int k = 0; k < sz; k++) mmem[ba + k] = e.data[8*k +: 8];
        e_wb  = e.wb;
        e_alu = e.alu;
        e_rd  = e.rd;
        e_v   = !bub;
    endtask

    task automatic drive(input ins_t t);
        control_WB_in = t.wb;
        control_M_in  = t.m;
        PC_branch_in  = t.pc;
        zero_in       = t.zero;
        ALU_in        = t.alu;
        readDataB_in  = t.data;
        funct3_in     = t.f3;
        rd_in         = t.rd;
    endtask

    // One clock edge with the given EX input; model updated, outputs then stable
    task automatic step(input ins_t t, input bit stall, input bit flush);
        drive(t);
        stall_in = stall;
        flush_in = flush;
        @(posedge clock);
        if (!stall) retire(exm, exm_bub);
        if (flush) begin
            exm = t; exm.wb = 2'b00; exm.m = 3'b000; exm_bub = 1'b1;
        end else if (!stall) begin
            exm = t; exm_bub = 1'b0;
        end
        #1;
        stall_in = 1'b0;
        flush_in = 1'b0;
    endtask

    task automatic do_reset(input int n);
        ins_t t;
        t = mk(2'b11, 3'b111, 3'd2, 32'h10, 32'hFFFF_FFFF);
        t.zero = 1'b1;
        t.pc   = 32'h1234;
        drive(t);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        exm = '0; exm_bub = 1'b0;
        e_wb = '0; e_md = '0; e_alu = '0; e_rd = '0; e_mis = 1'b0; e_v = 1'b1;
    endtask

    task automatic test_reset();
        stall_in = 1'b0;
        flush_in = 1'b0;
        do_reset(2);
        checks++;
        if ({PCSrc_out, PC_branch_out} !== 33'h0) begin
            errors++;
            $display("FAIL reset_exmem: got pcsrc=%0b pc=%h, want 0", PCSrc_out, PC_branch_out);
        end
        checks++;
        if ({control_WB_out, memData_out, ALU_out, rd_out, misalign_out} !== 72'h0) begin
            errors++;
            $display("FAIL reset_memwb: got wb=%b md=%h alu=%h rd=%0d mis=%b, want 0",
                     control_WB_out, memData_out, ALU_out, rd_out, misalign_out);
        end
    endtask

    // Store in EX/MEM when reset hits must not write
    task automatic test_reset_store();
        step(st(3'd2, 32'h50, 32'h1111_2222), 0, 0);
        step(st(3'd2, 32'h50, 32'h3333_4444), 0, 0);
        do_reset(1);
        step(ld(3'd2, 32'h50), 0, 0);
        step('0, 0, 0);
        checks++;
        if (memData_out !== 32'h1111_2222) begin
            errors++;
            $display("FAIL reset_store: got %h want %h", memData_out, 32'h1111_2222);
        end
    endtask

    task automatic test_load_store();
        step(st(3'd2, 32'h10, 32'hDEAD_BEEF), 0, 0);
        step(ld(3'd2, 32'h10), 0, 0);
        step(ld(3'd0, 32'h13), 0, 0);
        checks++;
        if (memData_out !== 32'hDEAD_BEEF || memData_out !== e_md || control_WB_out !== 2'b11) begin
            errors++;
            $display("FAIL lw_after_sw: got %h wb=%b want %h wb=11", memData_out, control_WB_out, 32'hDEAD_BEEF);
        end
        step(ld(3'd4, 32'h13), 0, 0);
        checks++;
        if (memData_out !== 32'hFFFF_FFDE) begin
            errors++;
            $display("FAIL lb: got %h want %h", memData_out, 32'hFFFF_FFDE);
        end
        step(ld(3'd1, 32'h12), 0, 0);
        checks++;
        if (memData_out !== 32'h0000_00DE) begin
            errors++;
            $display("FAIL lbu: got %h want %h", memData_out, 32'h0000_00DE);
        end
        step('0, 0, 0);
        checks++;
        if (memData_out !== 32'hFFFF_DEAD) begin
            errors++;
            $display("FAIL lh: got %h want %h", memData_out, 32'hFFFF_DEAD);
        end
    endtask

    task automatic test_partial();
        step(st(3'd0, 32'h11, 32'h0000_0055), 0, 0);
        step(ld(3'd2, 32'h10), 0, 0);
        step(st(3'd1, 32'h12, 32'h0000_1234), 0, 0);
        checks++;
        if (memData_out !== 32'hDEAD_55EF) begin
            errors++;
            $display("FAIL sb: got %h want %h", memData_out, 32'hDEAD_55EF);
        end
        step(ld(3'd2, 32'h10), 0, 0);
        step('0, 0, 0);
        checks++;
        if (memData_out !== 32'h1234_55EF) begin
            errors++;
            $display("FAIL sh: got %h want %h", memData_out, 32'h1234_55EF);
        end
    endtask

    task automatic test_misalign();
        step(st(3'd2, 32'h20, 32'h0BAD_F00D), 0, 0);
        step(st(3'd2, 32'h22, 32'hFFFF_FFFF), 0, 0);
        step(ld(3'd2, 32'h20), 0, 0);
        checks++;
        if (misalign_out !== 1'b1) begin
            errors++;
            $display("FAIL sw_misalign_flag: got %b want 1", misalign_out);
        end
        step(ld(3'd1, 32'h21), 0, 0);
        checks++;
        if (memData_out !== 32'h0BAD_F00D || misalign_out !== 1'b0) begin
            errors++;
            $display("FAIL sw_misalign_nowrite: got %h mis=%b want %h mis=0", memData_out, misalign_out, 32'h0BAD_F00D);
        end
        step('0, 0, 0);
        checks++;
        if (memData_out !== 32'h0 || misalign_out !== 1'b1) begin
            errors++;
            $display("FAIL lh_misalign: got %h mis=%b want 0 mis=1", memData_out, misalign_out);
        end
        step('0, 0, 0);
        checks++;
        if (misalign_out !== 1'b0) begin
            errors++;
            $display("FAIL misalign_sticky: got %b want 0", misalign_out);
        end
    endtask

    task automatic test_branch_flush();
        ins_t b;
        b = mk(2'b00, 3'b100, 3'd0, 32'h0, 32'h0);
        b.zero = 1'b1;
        b.pc   = 32'h40;
        step(b, 0, 0);
        checks++;
        if (PCSrc_out !== 1'b1 || PC_branch_out !== 32'h40) begin
            errors++;
            $display("FAIL branch_taken: got pcsrc=%b pc=%h want 1 %h", PCSrc_out, PC_branch_out, 32'h40);
        end
        b.zero = 1'b0;
        b.pc   = 32'h80;
        step(b, 0, 0);
        checks++;
        if (PCSrc_out !== 1'b0 || PC_branch_out !== 32'h80) begin
            errors++;
            $display("FAIL branch_not_taken: got pcsrc=%b pc=%h want 0 %h", PCSrc_out, PC_branch_out, 32'h80);
        end
        step(st(3'd2, 32'h10, 32'hFFFF_FFFF), 0, 1);
        step(ld(3'd2, 32'h10), 0, 0);
        checks++;
        if (control_WB_out !== 2'b00 || memData_out !== 32'h0) begin
            errors++;
            $display("FAIL flush_bubble: got wb=%b md=%h want 00 0", control_WB_out, memData_out);
        end
        step('0, 0, 0);
        checks++;
        if (memData_out !== 32'h1234_55EF) begin
            errors++;
            $display("FAIL flush_nowrite: got %h want %h", memData_out, 32'h1234_55EF);
        end
    endtask

    task automatic test_stall();
        step(ld(3'd2, 32'h10), 0, 0);
        step(st(3'd2, 32'h30, 32'hA5A5_A5A5), 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(ld(3'd2, 32'h30), 1, 0);
            checks++;
            if (memData_out !== 32'h1234_55EF || control_WB_out !== 2'b11 || rd_out !== e_rd) begin
                errors++;
                $display("FAIL stall_hold: cyc %0d got md=%h wb=%b rd=%0d want %h 11 %0d",
                         i, memData_out, control_WB_out, rd_out, 32'h1234_55EF, e_rd);
            end
        end
        step(ld(3'd2, 32'h30), 0, 0);
        step(ld(3'd2, 32'h430), 0, 0);
        checks++;
        if (memData_out !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL stall_release_write: got %h want %h", memData_out, 32'hA5A5_A5A5);
        end
        step('0, 0, 0);
        checks++;
        if (memData_out !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL addr_wrap: got %h want %h", memData_out, 32'hA5A5_A5A5);
        end
    endtask

    task automatic test_random();
        ins_t t;
        bit   s, f;
        for (int w = 0; w < 256; w++) step(st(3'd2, 32'(w * 4), $urandom), 0, 0);
        for (int i = 0; i < 400; i++) begin
            t      = '0;
            t.wb   = 2'($urandom);
            t.m    = 3'($urandom);
            t.pc   = $urandom;
            t.zero = 1'($urandom);
            t.alu  = $urandom_range(0, 32'hFFF);
            if ($urandom_range(0, 3) != 0) t.alu[1:0] = 2'b00;
            t.data = $urandom;
            t.f3   = 3'($urandom);
            t.rd   = 5'($urandom);
            s = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 9) == 0);
            step(t, s, f);
            checks++;
            if (PCSrc_out !== (exm.m[2] & exm.zero) || (!exm_bub && PC_branch_out !== exm.pc)) begin
                errors++;
                $display("FAIL rnd_branch: i=%0d got pcsrc=%b pc=%h want %b %h",
                         i, PCSrc_out, PC_branch_out, exm.m[2] & exm.zero, exm.pc);
            end
            checks++;
            if (control_WB_out !== e_wb || memData_out !== e_md || misalign_out !== e_mis) begin
                errors++;
                $display("FAIL rnd_memwb: i=%0d got wb=%b md=%h mis=%b want %b %h %b",
                         i, control_WB_out, memData_out, misalign_out, e_wb, e_md, e_mis);
            end
            if (e_v) begin
                checks++;
                if (ALU_out !== e_alu || rd_out !== e_rd) begin
                    errors++;
                    $display("FAIL rnd_pass: i=%0d got alu=%h rd=%0d want %h %0d",
                             i, ALU_out, rd_out, e_alu, e_rd);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        stall_in = 1'b0;
        flush_in = 1'b0;
        drive('0);
        #2;
        test_reset();
        test_reset_store();
        test_load_store();
        test_partial();
        test_misalign();
        test_branch_flush();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
